// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the RV32M multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    // Handshake: a request is taken on a rising edge where start is high and busy is low.
    // op/a/b need only be valid on that edge. done pulses for exactly one cycle with
    // result/div_zero valid; both then hold until overwritten by the next operation.
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             div_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, div_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_FAST_MUL_EN: MUL* ops use a single-cycle combinational multiplier instead.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       rst,
    muldiv_if.slave    bus,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic [WIDTH:0]   opnd_q, opnd_d;
    logic [WIDTH:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             div_zero_q, div_zero_d;

    // ---------------- request decode ----------------
    logic           in_div;
    logic           a_signed;
    logic           b_signed;
    logic           a_neg;
    logic           b_neg;
    logic [WIDTH:0] mag_a;
    logic [WIDTH:0] mag_b;
    logic           b_zero;
    logic           div_ovf;
    logic           early_exit;
    logic           take_start;
    logic           last_iter;

    always_comb begin
        in_div     = bus.op[2];
        a_signed   = (bus.op != OP_MULHU) && (bus.op != OP_DIVU) && (bus.op != OP_REMU);
        b_signed   = a_signed && (bus.op != OP_MULHSU);
        a_neg      = a_signed && bus.a[WIDTH-1];
        b_neg      = b_signed && bus.b[WIDTH-1];
        // One extra bit so the most-negative operand negates to a correct magnitude.
        mag_a      = a_neg ? -{1'b1, bus.a} : {1'b0, bus.a};
        mag_b      = b_neg ? -{1'b1, bus.b} : {1'b0, bus.b};
        b_zero     = (bus.b == '0);
        div_ovf    = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                     (bus.a == MOST_NEG) && (bus.b == '1);
        early_exit = in_div ? (b_zero || div_ovf) : FAST_MUL;
        take_start = (state_q == S_IDLE) && bus.start;
        last_iter  = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // ---------------- single iteration step ----------------
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic [WIDTH:0]   step_hi;
    logic [WIDTH-1:0] step_lo;

    always_comb begin
        mul_sum   = acc_hi_q + (acc_lo_q[0] ? opnd_q : '0);
        div_shift = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {1'b0, opnd_q};
        if (op_q[2]) begin
            // Restoring divide: keep the difference only when it did not go negative.
            step_hi = div_diff[WIDTH+1] ? div_shift : div_diff[WIDTH:0];
            step_lo = {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
        end else begin
            step_hi = {1'b0, mul_sum[WIDTH:1]};
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    // ---------------- sign fix and output select after the last step ----------------
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   calc_result;

    always_comb begin
        prod_mag = {step_hi[WIDTH-1:0], step_lo};
        prod_fix = neg_q ? -prod_mag : prod_mag;
        quo_fix  = neg_q ? -step_lo : step_lo;
        rem_fix  = neg_q ? -step_hi[WIDTH-1:0] : step_hi[WIDTH-1:0];
        case (op_q)
            OP_MUL:                        calc_result = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  calc_result = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:               calc_result = quo_fix;
            default:                       calc_result = rem_fix;
        endcase
    end

    // ---------------- early-exit result ----------------
    logic [WIDTH-1:0] early_result;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_a;
    logic [2*WIDTH-1:0] fast_b;
    logic [2*WIDTH-1:0] fast_prod;

    always_comb begin
        fast_a    = {{WIDTH{a_neg}}, bus.a};
        fast_b    = {{WIDTH{b_neg}}, bus.b};
        fast_prod = fast_a * fast_b;
    end
`endif

    always_comb begin
        early_result = '0;
        if (in_div) begin
            // op[1] distinguishes REM/REMU from DIV/DIVU.
            if (b_zero) begin
                early_result = bus.op[1] ? bus.a : '1;
            end else begin
                early_result = bus.op[1] ? '0 : bus.a;
            end
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (bus.op == OP_MUL) begin
            early_result = fast_prod[WIDTH-1:0];
        end else begin
            early_result = fast_prod[2*WIDTH-1:WIDTH];
        end
`endif
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (take_start) begin
                    state_d = early_exit ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (last_iter) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.busy     = (state_q != S_IDLE);
        bus.done     = (state_q == S_DONE);
        bus.result   = result_q;
        bus.div_zero = div_zero_q;
        dbg_state    = state_q;
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        op_d       = op_q;
        neg_d      = neg_q;
        opnd_d     = opnd_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        div_zero_d = div_zero_q;
        if (take_start) begin
            op_d     = bus.op;
            cnt_d    = '0;
            neg_d    = (bus.op == OP_REM) ? a_neg : (a_neg ^ b_neg);
            opnd_d   = in_div ? mag_b : mag_a;
            acc_hi_d = '0;
            acc_lo_d = in_div ? mag_a[WIDTH-1:0] : mag_b[WIDTH-1:0];
            if (early_exit) begin
                result_d   = early_result;
                div_zero_d = in_div && b_zero;
            end
        end else if (state_q == S_CALC) begin
            acc_hi_d = step_hi;
            acc_lo_d = step_lo;
            cnt_d    = cnt_q + 1'b1;
            if (last_iter) begin
                result_d   = calc_result;
                div_zero_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= '0;
            neg_q      <= 1'b0;
            opnd_q     <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            op_q       <= op_d;
            neg_q      <= neg_d;
            opnd_q     <= opnd_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M corner cases plus randomized ops
// checked against a 64-bit arithmetic reference model. Honours MULDIV_FAST_MUL_EN latency.
module tb_muldiv_unit;

    localparam int W = 32;
    localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b,
                                      output logic [W-1:0] res, output logic dz);
        logic signed [2*W-1:0] sa, sb, ua, ub, p;
        sa  = {{W{a[W-1]}}, a};
        sb  = {{W{b[W-1]}}, b};
        ua  = {{W{1'b0}}, a};
        ub  = {{W{1'b0}}, b};
        dz  = 1'b0;
        res = '0;
        case (op)
            3'd0: begin p = sa * sb; res = p[W-1:0]; end
            3'd1: begin p = sa * sb; res = p[2*W-1:W]; end
            3'd2: begin p = sa * ub; res = p[2*W-1:W]; end
            3'd3: begin p = ua * ub; res = p[2*W-1:W]; end
            3'd4: begin
                if (b == '0) begin res = '1; dz = 1'b1; end
                else if (a == MIN_NEG && b == '1) res = a;
                else begin p = sa / sb; res = p[W-1:0]; end
            end
            3'd5: begin
                if (b == '0) begin res = '1; dz = 1'b1; end
                else begin p = ua / ub; res = p[W-1:0]; end
            end
            3'd6: begin
                if (b == '0) begin res = a; dz = 1'b1; end
                else if (a == MIN_NEG && b == '1) res = '0;
                else begin p = sa % sb; res = p[W-1:0]; end
            end
            default: begin
                if (b == '0) begin res = a; dz = 1'b1; end
                else begin p = ua % ub; res = p[W-1:0]; end
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
        if (op[2]) begin
            if (b == '0) return 1;
            if ((op == 3'd4 || op == 3'd6) && a == MIN_NEG && b == '1) return 1;
            return W + 1;
        end
`ifdef MULDIV_FAST_MUL_EN
        return 1;
`else
        return W + 1;
`endif
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'd1;
            2:       return '1;
            3:       return MIN_NEG;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // ---------------- driver ----------------
    // Issues one op, optionally re-pulses start during CALC and in the done cycle,
    // then checks latency, busy, result, div_zero, done width and result hold.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit repulse);
        logic [W-1:0] er;
        logic         edz;
        logic [W-1:0] exp_res;
        int           lat;
        int           cyc;
        ref_model(op, a, b, er, edz);
        exp_q.push_back(er);
        lat = exp_latency(op, a, b);

        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'($urandom_range(0, 7));
        bus.a     = $urandom;
        bus.b     = $urandom;
        cyc = 1;
        check_eq({tag, " busy_after_start"}, 32'(bus.busy), 32'd1);
        check_eq({tag, " first_state"}, 32'(dbg_state), (lat == 1) ? 32'd2 : 32'd1);
        while (!bus.done && cyc < 60) begin
            bus.start = (repulse && cyc == 5);
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        check_eq({tag, " latency"}, 32'(cyc), 32'(lat));
        exp_res = exp_q.pop_front();
        check_eq({tag, " result"}, bus.result, exp_res);
        check_eq({tag, " div_zero"}, 32'(bus.div_zero), 32'(edz));

        if (repulse) bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq({tag, " done_pulse_width"}, 32'(bus.done), 32'd0);
        check_eq({tag, " idle_after_done"}, 32'(bus.busy), 32'd0);
        check_eq({tag, " result_held"}, bus.result, exp_res);
    endtask

    task automatic reset_midop();
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd5;
        bus.a     = 32'd1000;
        bus.b     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midop_rst busy", 32'(bus.busy), 32'd0);
        check_eq("midop_rst done", 32'(bus.done), 32'd0);
        check_eq("midop_rst result", bus.result, 32'd0);
        check_eq("midop_rst div_zero", 32'(bus.div_zero), 32'd0);
        check_eq("midop_rst state", 32'(dbg_state), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [2:0]   rop;
        logic [W-1:0] ra, rb;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset busy", 32'(bus.busy), 32'd0);
        check_eq("reset done", 32'(bus.done), 32'd0);
        check_eq("reset result", bus.result, 32'd0);
        check_eq("reset div_zero", 32'(bus.div_zero), 32'd0);
        check_eq("reset state", 32'(dbg_state), 32'd0);

        run_op("mul_7_m3",        3'd0, 32'd7,        32'hFFFF_FFFD, 1'b0);
        run_op("mulhu_ones",      3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mulh_ones",       3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mulhsu_m1_2",     3'd2, 32'hFFFF_FFFF, 32'd2,        1'b0);
        run_op("div_m7_2",        3'd4, 32'hFFFF_FFF9, 32'd2,        1'b0);
        run_op("rem_m7_2",        3'd6, 32'hFFFF_FFF9, 32'd2,        1'b0);
        run_op("divu_100_7",      3'd5, 32'd100,      32'd7,         1'b0);
        run_op("remu_100_7",      3'd7, 32'd100,      32'd7,         1'b0);
        run_op("divu_by0",        3'd5, 32'd100,      32'd0,         1'b0);
        run_op("remu_by0",        3'd7, 32'd100,      32'd0,         1'b0);
        reset_midop();
        run_op("after_rst_divu",  3'd5, 32'd1000,     32'd3,         1'b0);
        run_op("div_ovf",         3'd4, MIN_NEG,      32'hFFFF_FFFF, 1'b0);
        run_op("rem_ovf",         3'd6, MIN_NEG,      32'hFFFF_FFFF, 1'b0);
        run_op("div_repulse",     3'd4, 32'd12345,    32'hFFFF_FFF0, 1'b1);
        run_op("mulh_minneg",     3'd1, MIN_NEG,      MIN_NEG,       1'b1);
        run_op("rem_minneg_3",    3'd6, MIN_NEG,      32'd3,         1'b0);

        for (int i = 0; i < 120; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick_operand();
            rb  = pick_operand();
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
